cr_lz77_comp_tile_nb: RTL and testbench

Parametrised LZ77 compare tile for the cr_lz77_comp engine, the next generation of the fixed 4-byte tile. It holds DEPTH bytes of history in a byte-granular shift chain that accepts 0..IN_BYTES bytes per shift. It compares each input word, using the following word as lookahead, against that history and reports the nearest tile-local match offset per byte position. Tiles are chained through shift_data_out; the cluster adds each tile's base offset.

---
 rtl/cr_lz77_comp_tile_nb_if.sv | 58 +++++
 rtl/cr_lz77_comp_tile_nb.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cr_lz77_comp_tile_nb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_lz77_comp_tile_nb_if.sv
// ---------------------------------------------------------------------------
// cr_lz77_comp_tile_nb_if
//
// Bundles the shift-chain, input-word and match-result signals of one LZ77
// compare tile.
//   master : cluster side. Drives shift/input/control and receives the
//            evicted bytes and match results.
//   slave  : tile side.
//
// Signals
//   shift_en, shift_cnt, shift_data       bytes entering the history chain
//   shift_data_out, shift_data_out_vld    bytes evicted from the tile
//   input_en, input_data, input_vld,
//   input_last                            input word stream
//   tile_enable, clr_valid                tile controls
//   match_stb, match_vld, match_offset    registered match results
// ---------------------------------------------------------------------------
interface cr_lz77_comp_tile_nb_if #(
    parameter int IN_BYTES = 4,
    parameter int DEPTH    = 64
);
    localparam int CW = $clog2(IN_BYTES + 1);
    localparam int OW = $clog2(DEPTH);

    logic                     shift_en;
    logic [CW-1:0]            shift_cnt;
    logic [IN_BYTES*8-1:0]    shift_data;
    logic [IN_BYTES*8-1:0]    shift_data_out;
    logic [IN_BYTES-1:0]      shift_data_out_vld;

    logic                     input_en;
    logic [IN_BYTES*8-1:0]    input_data;
    logic [IN_BYTES-1:0]      input_vld;
    logic                     input_last;

    logic                     tile_enable;
    logic                     clr_valid;

    logic                     match_stb;
    logic [IN_BYTES-1:0]      match_vld;
    logic [IN_BYTES*OW-1:0]   match_offset;

    modport master (
        output shift_en, shift_cnt, shift_data,
        input  shift_data_out, shift_data_out_vld,
        output input_en, input_data, input_vld, input_last,
        output tile_enable, clr_valid,
        input  match_stb, match_vld, match_offset
    );

    modport slave (
        input  shift_en, shift_cnt, shift_data,
        output shift_data_out, shift_data_out_vld,
        input  input_en, input_data, input_vld, input_last,
        input  tile_enable, clr_valid,
        output match_stb, match_vld, match_offset
    );
endinterface

// File: rtl/cr_lz77_comp_tile_nb.sv
// ---------------------------------------------------------------------------
// cr_lz77_comp_tile_nb
//
// LZ77 compare tile. Keeps DEPTH bytes of history (hb[0] newest) in a
// byte-granular shift chain that takes 0..IN_BYTES bytes per shift, and
// compares each pending input word (with the following word as lookahead)
// against that history. For every byte position of the pending word it
// reports the smallest tile-local index i where MIN_MATCH bytes match.
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   tile_if  slave side of cr_lz77_comp_tile_nb_if (shift chain, input
//            words, controls, registered match results)
// ---------------------------------------------------------------------------
module cr_lz77_comp_tile_nb #(
    parameter int IN_BYTES  = 4,
    parameter int DEPTH     = 64,
    parameter int MIN_MATCH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cr_lz77_comp_tile_nb_if.slave  tile_if
);
    localparam int CW = $clog2(IN_BYTES + 1);
    localparam int OW = $clog2(DEPTH);
    localparam int LW = CW + 1;          // holds P count + lookahead count
    localparam int EB = 2 * IN_BYTES;    // evaluation window bytes

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // History shift chain
    // -----------------------------------------------------------------------
    logic [7:0]            hb_reg  [DEPTH];
    logic [7:0]            hb_next [DEPTH];
    logic [DEPTH-1:0]      hv_reg;
    logic [DEPTH-1:0]      hv_next;
    logic [DEPTH-1:0]      hv_base;
    logic [IN_BYTES*8-1:0] evict_data;
    logic [IN_BYTES-1:0]   evict_vld;
    logic [IN_BYTES*8-1:0] sdo_data_reg;
    logic [IN_BYTES-1:0]   sdo_vld_reg;

    always_comb begin
        // clr_valid drops the old valids before the shift, so only bytes
        // entering this cycle survive as valid.
        hv_base    = tile_if.clr_valid ? '0 : hv_reg;
        hb_next    = hb_reg;
        hv_next    = hv_base;
        evict_data = '0;
        evict_vld  = '0;
        if (tile_if.shift_en) begin
            for (int k = 1; k <= IN_BYTES; k++) begin
                if (int'(tile_if.shift_cnt) == k) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i >= k) begin
                            hb_next[i] = hb_reg[i-k];
                            hv_next[i] = hv_base[i-k];
                        end else begin
                            // shift_data byte 0 is oldest, so it lands deepest
                            hb_next[i] = tile_if.shift_data[(k-1-i)*8 +: 8];
                            hv_next[i] = 1'b1;
                        end
                    end
                    for (int j = 0; j < k; j++) begin
                        evict_data[j*8 +: 8] = hb_reg[DEPTH-1-j];
                        evict_vld[j]         = hv_reg[DEPTH-1-j] & ~tile_if.clr_valid;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hb_reg[i] <= '0;
            end
            hv_reg       <= '0;
            sdo_data_reg <= '0;
            sdo_vld_reg  <= '0;
        end else begin
            hb_reg       <= hb_next;
            hv_reg       <= hv_next;
            sdo_data_reg <= evict_data;
            sdo_vld_reg  <= evict_vld;
        end
    end

    assign tile_if.shift_data_out     = sdo_data_reg;
    assign tile_if.shift_data_out_vld = sdo_vld_reg;

    // -----------------------------------------------------------------------
    // Input FSM and pending word P. The stream's last flag is carried by the
    // LAST state itself rather than a separate register.
    // -----------------------------------------------------------------------
    state_t                state_reg;
    state_t                state_next;
    state_t                load_state;
    logic                  load_p;
    logic                  eval_fire;
    logic [CW-1:0]         in_cnt;
    logic [IN_BYTES*8-1:0] p_data_reg;
    logic [CW-1:0]         p_cnt_reg;

    // input_vld is contiguous from bit 0, so its popcount is the byte count
    always_comb begin
        in_cnt = '0;
        for (int j = 0; j < IN_BYTES; j++) begin
            if (tile_if.input_vld[j]) begin
                in_cnt = in_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load_p     = 1'b0;
        eval_fire  = 1'b0;
        load_state = tile_if.input_last ? ST_LAST : ST_HOLD;
        if (tile_if.clr_valid) begin
            // stream boundary: pending word dropped without a strobe
            if (tile_if.input_en) begin
                load_p     = 1'b1;
                state_next = load_state;
            end else begin
                state_next = ST_IDLE;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (tile_if.input_en) begin
                        load_p     = 1'b1;
                        state_next = load_state;
                    end
                end
                ST_HOLD: begin
                    if (tile_if.input_en) begin
                        eval_fire  = 1'b1;
                        load_p     = 1'b1;
                        state_next = load_state;
                    end
                end
                ST_LAST: begin
                    eval_fire = 1'b1;
                    if (tile_if.input_en) begin
                        load_p     = 1'b1;
                        state_next = load_state;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            p_data_reg <= '0;
            p_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (load_p) begin
                p_data_reg <= tile_if.input_data;
                p_cnt_reg  <= in_cnt;
            end else if (state_next == ST_IDLE) begin
                p_cnt_reg  <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Evaluation window E = P bytes then lookahead bytes. A non-last P is
    // always full, so plain concatenation is correct; bytes past e_len are
    // excluded by the length test.
    // -----------------------------------------------------------------------
    logic [7:0]    e_bytes [EB];
    logic [CW-1:0] la_cnt;
    logic [LW-1:0] e_len;

    always_comb begin
        for (int q = 0; q < EB; q++) begin
            if (q < IN_BYTES) begin
                e_bytes[q] = p_data_reg[q*8 +: 8];
            end else begin
                e_bytes[q] = tile_if.input_data[(q-IN_BYTES)*8 +: 8];
            end
        end
        la_cnt = (state_reg == ST_HOLD && tile_if.input_en) ? in_cnt : '0;
        e_len  = LW'(p_cnt_reg) + LW'(la_cnt);
    end

    // hit[p*DEPTH+i]: position p of P matches MIN_MATCH bytes ending at hb[i-MIN_MATCH+1]
    logic [IN_BYTES*DEPTH-1:0] hit;
    logic [IN_BYTES-1:0]       pos_vld;
    logic [IN_BYTES*OW-1:0]    pos_off;

    generate
        for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_pos
            for (genvar gj = 0; gj < DEPTH; gj++) begin : g_idx
                if (gj >= MIN_MATCH - 1) begin : g_cmp
                    logic [MIN_MATCH-1:0] eq;
                    for (genvar gm = 0; gm < MIN_MATCH; gm++) begin : g_byte
                        assign eq[gm] = hv_reg[gj-gm]
                                     && (e_bytes[gi+gm] == hb_reg[gj-gm])
                                     && (LW'(gi + gm) < e_len);
                    end
                    assign hit[gi*DEPTH+gj] = &eq;
                end else begin : g_short
                    // too close to hb[0] to fit MIN_MATCH bytes
                    assign hit[gi*DEPTH+gj] = 1'b0;
                end
            end

            // nearest-first: scanning downwards leaves the smallest index
            logic          vld_l;
            logic [OW-1:0] off_l;
            always_comb begin
                vld_l = 1'b0;
                off_l = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (hit[gi*DEPTH+i]) begin
                        vld_l = 1'b1;
                        off_l = OW'(i);
                    end
                end
            end

            logic pos_ok;
            assign pos_ok                 = vld_l && (CW'(gi) < p_cnt_reg);
            assign pos_vld[gi]            = pos_ok;
            assign pos_off[gi*OW +: OW]   = pos_ok ? off_l : '0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Registered results
    // -----------------------------------------------------------------------
    logic                   match_stb_reg;
    logic [IN_BYTES-1:0]    match_vld_reg;
    logic [IN_BYTES*OW-1:0] match_off_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_stb_reg <= 1'b0;
            match_vld_reg <= '0;
            match_off_reg <= '0;
        end else begin
            match_stb_reg <= eval_fire;
            match_vld_reg <= (eval_fire && tile_if.tile_enable) ? pos_vld : '0;
            match_off_reg <= (eval_fire && tile_if.tile_enable) ? pos_off : '0;
        end
    end

    assign tile_if.match_stb    = match_stb_reg;
    assign tile_if.match_vld    = match_vld_reg;
    assign tile_if.match_offset = match_off_reg;

    // Only the last word of a stream may be partial.
    a_partial_needs_last: assert property (@(posedge clk) disable iff (!rst_n)
        (tile_if.input_en && !tile_if.input_last) |-> (&tile_if.input_vld));

    a_shift_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        tile_if.shift_en |-> (int'(tile_if.shift_cnt) <= IN_BYTES));

endmodule

// File: tb/tb_cr_lz77_comp_tile_nb.sv
// ---------------------------------------------------------------------------
// tb_cr_lz77_comp_tile_nb
//
// Directed bench for cr_lz77_comp_tile_nb with IN_BYTES=4, DEPTH=16,
// MIN_MATCH=4. Inputs change on the falling edge; registered outputs are
// observed on the following falling edge.
// ---------------------------------------------------------------------------
module tb_cr_lz77_comp_tile_nb;
    localparam int IB = 4;
    localparam int DP = 16;
    localparam int MM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cr_lz77_comp_tile_nb_if #(.IN_BYTES(IB), .DEPTH(DP)) bus ();

    cr_lz77_comp_tile_nb #(
        .IN_BYTES (IB),
        .DEPTH    (DP),
        .MIN_MATCH(MM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tile_if(bus)
    );

    int checks = 0;
    int errors = 0;

    // "abcd" literal -> byte 0 = 'a'
    function automatic logic [31:0] w(input logic [31:0] s);
        return {s[7:0], s[15:8], s[23:16], s[31:24]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.shift_en   = 1'b0;
        bus.shift_cnt  = '0;
        bus.shift_data = '0;
        bus.input_en   = 1'b0;
        bus.input_data = '0;
        bus.input_vld  = '0;
        bus.input_last = 1'b0;
        bus.clr_valid  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        bus.tile_enable = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic shift(input logic [2:0] cnt, input logic [31:0] data);
        bus.shift_en   = 1'b1;
        bus.shift_cnt  = cnt;
        bus.shift_data = data;
        step();
        $display("[%0t] shift cnt=%0d data=%h -> out=%h vld=%b", $time, cnt, data,
                 bus.shift_data_out, bus.shift_data_out_vld);
        bus.shift_en   = 1'b0;
        bus.shift_cnt  = '0;
        bus.shift_data = '0;
    endtask

    task automatic word(input logic [31:0] data, input logic [3:0] vld, input logic last);
        bus.input_en   = 1'b1;
        bus.input_data = data;
        bus.input_vld  = vld;
        bus.input_last = last;
        step();
        $display("[%0t] input data=%h vld=%b last=%0b -> stb=%0b mvld=%b off=%h", $time,
                 data, vld, last, bus.match_stb, bus.match_vld, bus.match_offset);
        bus.input_en   = 1'b0;
        bus.input_data = '0;
        bus.input_vld  = '0;
        bus.input_last = 1'b0;
    endtask

    task automatic fill_0_to_15();
        logic [31:0] d;
        for (int n = 0; n < 4; n++) begin
            for (int b = 0; b < 4; b++) d[b*8 +: 8] = 8'(4*n + b);
            shift(3'd4, d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'h0) begin errors++; $display("FAIL reset_vld: got %b want 0000", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h0) begin errors++; $display("FAIL reset_off: got %h want 0000", bus.match_offset); end
        checks++; if (bus.shift_data_out !== 32'h0) begin errors++; $display("FAIL reset_sdo: got %h want 0", bus.shift_data_out); end
        checks++; if (bus.shift_data_out_vld !== 4'h0) begin errors++; $display("FAIL reset_sdo_vld: got %b want 0000", bus.shift_data_out_vld); end
        checks++; if (dut.hv_reg !== 16'h0) begin errors++; $display("FAIL reset_hv: got %h want 0000", dut.hv_reg); end
    endtask

    task automatic test_match_basic();
        do_reset();
        shift(3'd4, w("abcd"));
        checks++; if (bus.shift_data_out_vld !== 4'h0) begin errors++; $display("FAIL basic_sdo_vld: got %b want 0000", bus.shift_data_out_vld); end
        word(w("abcd"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL basic_first_stb: got %b want 0", bus.match_stb); end
        word(w("efgh"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL basic_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'b0001) begin errors++; $display("FAIL basic_vld: got %b want 0001", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h0003) begin errors++; $display("FAIL basic_off: got %h want 0003", bus.match_offset); end
        step();
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL basic_hold_stb: got %b want 0", bus.match_stb); end
    endtask

    task automatic test_evict();
        do_reset();
        fill_0_to_15();
        checks++; if (bus.shift_data_out_vld !== 4'h0) begin errors++; $display("FAIL evict_fill_vld: got %b want 0000", bus.shift_data_out_vld); end
        shift(3'd4, 32'h13121110);
        checks++; if (bus.shift_data_out !== 32'h03020100) begin errors++; $display("FAIL evict_data: got %h want 03020100", bus.shift_data_out); end
        checks++; if (bus.shift_data_out_vld !== 4'b1111) begin errors++; $display("FAIL evict_vld: got %b want 1111", bus.shift_data_out_vld); end
        shift(3'd0, 32'hffffffff);
        checks++; if (bus.shift_data_out !== 32'h0) begin errors++; $display("FAIL evict_k0_data: got %h want 0", bus.shift_data_out); end
        checks++; if (bus.shift_data_out_vld !== 4'h0) begin errors++; $display("FAIL evict_k0_vld: got %b want 0000", bus.shift_data_out_vld); end
        shift(3'd2, 32'h00002120);
        checks++; if (bus.shift_data_out !== 32'h00000504) begin errors++; $display("FAIL evict_k2_data: got %h want 00000504", bus.shift_data_out); end
        checks++; if (bus.shift_data_out_vld !== 4'b0011) begin errors++; $display("FAIL evict_k2_vld: got %b want 0011", bus.shift_data_out_vld); end
        checks++; if (dut.hb_reg[0] !== 8'h21) begin errors++; $display("FAIL evict_k2_hb0: got %h want 21", dut.hb_reg[0]); end
    endtask

    task automatic test_partial_last();
        do_reset();
        shift(3'd3, 32'h007a7978);   // x,y,z in bytes 0..2
        checks++; if (dut.hb_reg[2] !== 8'h78) begin errors++; $display("FAIL part_hb2: got %h want 78", dut.hb_reg[2]); end
        checks++; if (dut.hb_reg[1] !== 8'h79) begin errors++; $display("FAIL part_hb1: got %h want 79", dut.hb_reg[1]); end
        checks++; if (dut.hb_reg[0] !== 8'h7a) begin errors++; $display("FAIL part_hb0: got %h want 7a", dut.hb_reg[0]); end
        checks++; if (bus.shift_data_out_vld !== 4'h0) begin errors++; $display("FAIL part_sdo_vld: got %b want 0000", bus.shift_data_out_vld); end
        word(32'h007a7978, 4'b0111, 1'b1);
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL part_load_stb: got %b want 0", bus.match_stb); end
        step();
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL part_flush_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'h0) begin errors++; $display("FAIL part_flush_vld: got %b want 0000", bus.match_vld); end
        step();
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL part_idle_stb: got %b want 0", bus.match_stb); end
    endtask

    task automatic test_clr_valid();
        do_reset();
        shift(3'd4, w("abcd"));
        bus.clr_valid = 1'b1;
        shift(3'd2, 32'h00006463);   // c,d
        bus.clr_valid = 1'b0;
        checks++; if (bus.shift_data_out_vld !== 4'h0) begin errors++; $display("FAIL clr_sdo_vld: got %b want 0000", bus.shift_data_out_vld); end
        checks++; if (dut.hv_reg !== 16'h0003) begin errors++; $display("FAIL clr_hv: got %h want 0003", dut.hv_reg); end
        word(w("abcd"), 4'hf, 1'b0);
        word(w("zzzz"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL clr_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'h0) begin errors++; $display("FAIL clr_vld: got %b want 0000", bus.match_vld); end
        // boundary while a word is pending, with a new stream starting at once
        bus.clr_valid  = 1'b1;
        bus.shift_en   = 1'b1;
        bus.shift_cnt  = 3'd4;
        bus.shift_data = w("abcd");
        word(w("abcd"), 4'hf, 1'b0);
        clear_inputs();
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL clr_discard_stb: got %b want 0", bus.match_stb); end
        word(w("efgh"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL clr_new_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'b0001) begin errors++; $display("FAIL clr_new_vld: got %b want 0001", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h0003) begin errors++; $display("FAIL clr_new_off: got %h want 0003", bus.match_offset); end
    endtask

    task automatic test_tile_disable();
        do_reset();
        bus.tile_enable = 1'b0;
        fill_0_to_15();
        shift(3'd4, w("abcd"));
        checks++; if (bus.shift_data_out !== 32'h03020100) begin errors++; $display("FAIL dis_sdo: got %h want 03020100", bus.shift_data_out); end
        checks++; if (bus.shift_data_out_vld !== 4'b1111) begin errors++; $display("FAIL dis_sdo_vld: got %b want 1111", bus.shift_data_out_vld); end
        word(w("abcd"), 4'hf, 1'b0);
        word(w("efgh"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL dis_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'h0) begin errors++; $display("FAIL dis_vld: got %b want 0000", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h0) begin errors++; $display("FAIL dis_off: got %h want 0000", bus.match_offset); end
        bus.tile_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        shift(3'd4, w("abcd"));
        word(w("abcd"), 4'hf, 1'b0);
        word(w("efgh"), 4'hf, 1'b0);
        checks++; if (bus.match_vld !== 4'b0001) begin errors++; $display("FAIL mid_pre_vld: got %b want 0001", bus.match_vld); end
        bus.input_en   = 1'b1;
        bus.input_data = w("ijkl");
        bus.input_vld  = 4'hf;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL mid_stb: got %b want 0", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'h0) begin errors++; $display("FAIL mid_vld: got %b want 0000", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h0) begin errors++; $display("FAIL mid_off: got %h want 0000", bus.match_offset); end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        step();
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL mid_post_stb: got %b want 0", bus.match_stb); end
        word(w("efgh"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL mid_reload_stb: got %b want 0", bus.match_stb); end
        word(w("ijkl"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL mid_eval_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'h0) begin errors++; $display("FAIL mid_eval_vld: got %b want 0000", bus.match_vld); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        shift(3'd4, w("abcd"));
        shift(3'd4, w("abcd"));
        word(w("abcd"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL b2b_load_stb: got %b want 0", bus.match_stb); end
        word(w("abca"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL b2b_w1_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'b1111) begin errors++; $display("FAIL b2b_w1_vld: got %b want 1111", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h4563) begin errors++; $display("FAIL b2b_w1_off: got %h want 4563", bus.match_offset); end
        // evaluation must see history from before this cycle's shift
        bus.shift_en   = 1'b1;
        bus.shift_cnt  = 3'd4;
        bus.shift_data = w("wxyz");
        word(w("bcda"), 4'hf, 1'b1);
        clear_inputs();
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL b2b_w2_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'b1000) begin errors++; $display("FAIL b2b_w2_vld: got %b want 1000", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h3000) begin errors++; $display("FAIL b2b_w2_off: got %h want 3000", bus.match_offset); end
        word(w("dddd"), 4'hf, 1'b0);
        checks++; if (bus.match_stb !== 1'b1) begin errors++; $display("FAIL b2b_w3_stb: got %b want 1", bus.match_stb); end
        checks++; if (bus.match_vld !== 4'b0001) begin errors++; $display("FAIL b2b_w3_vld: got %b want 0001", bus.match_vld); end
        checks++; if (bus.match_offset !== 16'h000a) begin errors++; $display("FAIL b2b_w3_off: got %h want 000a", bus.match_offset); end
        step();
        checks++; if (bus.match_stb !== 1'b0) begin errors++; $display("FAIL b2b_wait_stb: got %b want 0", bus.match_stb); end
    endtask

    initial begin
        clear_inputs();
        bus.tile_enable = 1'b1;
        test_reset();
        test_match_basic();
        test_evict();
        test_partial_last();
        test_clr_valid();
        test_tile_disable();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
